// File: rtl/tqvp_uart_tx_arbiter_if.sv
// Requester, arbiter and TX-engine signal bundle; the arbiter attaches through the slave modport.
interface tqvp_uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_tx_en;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_busy;
  logic [GW-1:0]        grant_id;
  logic                 locked;
  logic                 timeout_evt;

  modport master (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, uart_tx_en, uart_tx_data, grant_id, locked, timeout_evt
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, uart_tx_en, uart_tx_data, grant_id, locked, timeout_evt
  );
endinterface

// File: rtl/tqvp_uart_tx_arbiter.sv
// Round-robin, message-locked sharing of one UART TX engine; accept at N gives en at N+1.
// One byte in flight at a time: no req_ready until the engine's busy has risen and fallen.
module tqvp_uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 4096
) (
  input logic                   clk,
  input logic                   rst,
  tqvp_uart_tx_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HOLD, ACK, DONE} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] grant_q, grant_nxt;
  logic          locked_q, locked_nxt;
  logic [7:0]    data_q, data_nxt;
  logic [TW-1:0] timer_q, timer_nxt;
  logic          seen_q, seen_nxt;

  logic [GW-1:0]      cand, pick, acc_idx;
  logic               pick_vld, acc;
  logic [NUM_REQ-1:0] ready;
  logic               tmo;

  // First valid requester after the rotation pointer, wrapping; the pointer itself is checked last.
  always_comb begin
    cand     = grant_q;
    pick     = grant_q;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(grant_q) + k) % NUM_REQ);
      if (!pick_vld && bus.req_valid[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_q;
    locked_nxt = locked_q;
    data_nxt   = data_q;
    timer_nxt  = timer_q;
    seen_nxt   = seen_q;
    acc        = 1'b0;
    acc_idx    = grant_q;
    tmo        = 1'b0;

    case (state)
      IDLE: begin
        acc     = pick_vld && !bus.uart_tx_busy;
        acc_idx = pick;
      end
      HOLD: begin
        acc     = bus.req_valid[grant_q] && !bus.uart_tx_busy;
        acc_idx = grant_q;
        if (!acc) begin
          if (timer_q == TLAST) begin
            locked_nxt = 1'b0;
            tmo        = 1'b1;
            timer_nxt  = '0;
            state_nxt  = IDLE;
          end else begin
            timer_nxt = timer_q + 1'b1;
          end
        end
      end
      ACK: begin
        seen_nxt  = bus.uart_tx_busy;
        state_nxt = DONE;
      end
      DONE: begin
        if (bus.uart_tx_busy) begin
          seen_nxt = 1'b1;
        end else if (seen_q) begin
          state_nxt = locked_q ? HOLD : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (acc) begin
      data_nxt   = bus.req_data[{acc_idx, 3'b000} +: 8];
      grant_nxt  = acc_idx;
      locked_nxt = !bus.req_last[acc_idx];
      timer_nxt  = '0;
      seen_nxt   = 1'b0;
      state_nxt  = ACK;
    end

    ready = acc ? (NUM_REQ'(1) << acc_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= GW'(NUM_REQ - 1);
      locked_q <= 1'b0;
      data_q   <= '0;
      timer_q  <= '0;
      seen_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant_q  <= grant_nxt;
      locked_q <= locked_nxt;
      data_q   <= data_nxt;
      timer_q  <= timer_nxt;
      seen_q   <= seen_nxt;
    end
  end

  assign bus.req_ready    = ready;
  assign bus.uart_tx_en   = (state == ACK);
  assign bus.uart_tx_data = data_q;
  assign bus.grant_id     = grant_q;
  assign bus.locked       = locked_q;
  assign bus.timeout_evt  = tmo;
endmodule

// File: tb/tb_tqvp_uart_tx_arbiter.sv
// Random and directed stimulus for the UART TX arbiter, checked every cycle against a transaction-level model.
module tb_tqvp_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int LT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tqvp_uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  tqvp_uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int msg_left[N], prob[N], refill[N];
  logic [7:0] nxt_byte[N];
  bit v_arr[N], l_arr[N];
  logic [7:0] d_arr[N];
  int eng_delay, eng_flen, start_in, frame_left;
  bit eng_rand;
  // model: rotation pointer, message holder (-1 none), idle cycles of the holder, byte in flight
  int m_rr, m_holder, m_stall;
  bit m_inflight, m_seen, m_en_due;
  logic [7:0] m_data;
  int acc_log[$];
  int en_cnt, rdy_cnt, tmo_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_rr = N - 1; m_holder = -1; m_stall = 0;
    m_inflight = 0; m_seen = 0; m_en_due = 0; m_data = 8'h00;
  endtask

  task automatic drive();
    logic [N-1:0] rv, rl;
    logic [8*N-1:0] rd;
    rv = '0; rl = '0; rd = '0;
    for (int i = 0; i < N; i++) begin
      v_arr[i] = (msg_left[i] > 0) && ($urandom_range(99) < prob[i]);
      d_arr[i] = nxt_byte[i];
      l_arr[i] = (msg_left[i] == 1);
      rv |= N'(v_arr[i]) << i;
      rl |= N'(l_arr[i]) << i;
      rd |= (8*N)'(d_arr[i]) << (8*i);
    end
    bus.req_valid = rv;
    bus.req_last  = rl;
    bus.req_data  = rd;
    // TX engine: busy starts eng_delay cycles after en and lasts eng_flen cycles
    if (frame_left > 0) frame_left--;
    if (start_in > 0) start_in--;
    if (bus.uart_tx_en) begin
      if (eng_rand) begin
        eng_delay = $urandom_range(2);
        eng_flen  = $urandom_range(1, 6);
      end
      start_in = eng_delay;
    end
    if (start_in == 0) begin
      frame_left = eng_flen;
      start_in   = -1;
    end
    bus.uart_tx_busy = (frame_left > 0);
  endtask

  task automatic check_cycle();
    int acc;
    bit stalled, exp_tmo;
    logic [N-1:0] exp_rdy, tmp;
    acc = -1; exp_rdy = '0; exp_tmo = 0;
    if (!m_inflight && !bus.uart_tx_busy) begin
      if (m_holder >= 0) begin
        if (v_arr[m_holder]) acc = m_holder;
      end else begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (acc < 0 && v_arr[j]) acc = j;
        end
      end
    end
    if (acc >= 0) exp_rdy = N'(1) << acc;
    stalled = (m_holder >= 0) && !m_inflight && (acc < 0);
    if (stalled && (m_stall + 1 == LT)) exp_tmo = 1;

    chk("req_ready", bus.req_ready, exp_rdy);
    chk("uart_tx_en", bus.uart_tx_en, m_en_due);
    chk("uart_tx_data", bus.uart_tx_data, m_data);
    chk("grant_id", bus.grant_id, m_rr);
    chk("locked", bus.locked, m_holder >= 0);
    chk("timeout_evt", bus.timeout_evt, exp_tmo);

    if (bus.uart_tx_en) en_cnt++;
    if (|bus.req_ready) rdy_cnt++;
    for (int i = 0; i < N; i++) begin
      tmp = bus.req_ready >> i;
      if (tmp[0]) acc_log.push_back(i);
    end
    if (bus.timeout_evt) tmo_cyc = cyc;

    if (m_inflight) begin
      if (bus.uart_tx_busy) m_seen = 1;
      else if (m_seen) m_inflight = 0;
    end
    m_en_due = (acc >= 0);
    if (acc >= 0) begin
      m_data     = d_arr[acc];
      m_rr       = acc;
      m_holder   = l_arr[acc] ? -1 : acc;
      m_stall    = 0;
      m_inflight = 1;
      m_seen     = 0;
      msg_left[acc]--;
      nxt_byte[acc]++;
      if (msg_left[acc] == 0) begin
        if (refill[acc] == 1) msg_left[acc] = 1;
        else if (refill[acc] == 2) msg_left[acc] = $urandom_range(1, 4);
      end
    end else if (stalled) begin
      m_stall++;
      if (m_stall == LT) begin
        m_holder = -1;
        m_stall  = 0;
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    drive();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      msg_left[i] = 0; prob[i] = 100; refill[i] = 0;
      nxt_byte[i] = 8'(16 * i + 1);
      v_arr[i] = 0; l_arr[i] = 0; d_arr[i] = 8'h00;
    end
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.uart_tx_busy = 1'b0;
    start_in = -1; frame_left = 0; eng_rand = 0; eng_delay = 1; eng_flen = 4;
    model_reset();
    acc_log.delete();
    tmo_cyc = -1; en_cnt = 0; rdy_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.req_ready, 0);
    chk({tag, "_en"}, bus.uart_tx_en, 0);
    chk({tag, "_data"}, bus.uart_tx_data, 0);
    chk({tag, "_grant"}, bus.grant_id, N - 1);
    chk({tag, "_locked"}, bus.locked, 0);
    chk({tag, "_tmo"}, bus.timeout_evt, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1);
  end

  initial begin
    int n0, unl, bad, served, sz;

    // 1: single byte from requester 0, 10-cycle frame
    do_reset();
    chk_reset_vals("reset");
    msg_left[0] = 1; nxt_byte[0] = 8'h41; eng_delay = 1; eng_flen = 10;
    cycle(); chk("t1_ready", bus.req_ready, 4'b0001);
    cycle(); chk("t1_en", bus.uart_tx_en, 1); chk("t1_data", bus.uart_tx_data, 8'h41);
    repeat (11) cycle();
    msg_left[1] = 1;
    cycle(); chk("t1_next_ready", bus.req_ready, 4'b0010);

    // 2: all four requesters, single-byte messages
    do_reset();
    for (int i = 0; i < N; i++) begin msg_left[i] = 1; refill[i] = 1; end
    eng_flen = 2;
    for (int g = 0; g < 400 && acc_log.size() < 8; g++) cycle();
    for (int k = 0; k < 8; k++)
      chk($sformatf("t2_order%0d", k), (acc_log.size() > k) ? acc_log[k] : -1, k % 4);

    // 3: requester 2 sends a 3-byte message while requester 1 waits
    do_reset();
    msg_left[2] = 3;
    cycle();
    msg_left[1] = 1;
    unl = 0;
    for (int g = 0; g < 200 && acc_log.size() < 4; g++) begin
      sz = acc_log.size();
      cycle();
      if (sz >= 1 && sz <= 2 && !bus.locked) unl++;
    end
    chk("t3_b0", (acc_log.size() > 0) ? acc_log[0] : -1, 2);
    chk("t3_b1", (acc_log.size() > 1) ? acc_log[1] : -1, 2);
    chk("t3_b2", (acc_log.size() > 2) ? acc_log[2] : -1, 2);
    chk("t3_b3", (acc_log.size() > 3) ? acc_log[3] : -1, 1);
    chk("t3_unlocked_mid_msg", unl, 0);

    // 4: requester 0 stalls mid-message; accept N, en N+1, busy N+2..N+5, HOLD from N+7, 16th HOLD cycle N+22
    do_reset();
    msg_left[0] = 3; eng_delay = 1; eng_flen = 4;
    n0 = cyc;
    cycle(); chk("t4_accept", bus.req_ready, 4'b0001);
    prob[0] = 0; msg_left[1] = 1;
    for (int g = 0; g < 80 && tmo_cyc < 0; g++) cycle();
    chk("t4_timeout_cycle", tmo_cyc - n0, 22);
    cycle(); chk("t4_waiter_served", bus.req_ready, 4'b0010);

    // 5: reset while the engine is busy
    do_reset();
    msg_left[0] = 1; eng_flen = 8;
    for (int g = 0; g < 40 && !(bus.uart_tx_busy && !bus.uart_tx_en); g++) cycle();
    chk("t5_engine_busy", bus.uart_tx_busy, 1);
    msg_left[1] = 1;
    #2 rst = 1'b1;
    #1 chk_reset_vals("t5_async");
    model_reset();
    @(posedge clk); #2 rst = 1'b0;
    bad = 0; served = 0;
    for (int g = 0; g < 60 && !served; g++) begin
      cycle();
      if (bus.uart_tx_busy && |bus.req_ready) bad++;
      if (|bus.req_ready) served = 1;
    end
    chk("t5_ready_while_busy", bad, 0);
    chk("t5_served_after_busy", served, 1);

    // 6: engine variants (busy on en cycle, busy late, random) with random traffic
    do_reset();
    for (int i = 0; i < N; i++) begin
      refill[i] = 2; msg_left[i] = $urandom_range(1, 4); prob[i] = $urandom_range(5, 100);
    end
    eng_delay = 0; eng_flen = 3;
    repeat (400) cycle();
    eng_delay = 2; eng_flen = 2;
    repeat (400) cycle();
    eng_rand = 1;
    repeat (2500) cycle();
    chk("t6_one_en_per_byte", en_cnt, rdy_cnt - int'(m_en_due));
    chk("t6_activity", rdy_cnt > 100, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
